// File: rtl/store_buf_pkg.sv
// Shared types and opcode constants for the posted-store buffer.
package store_buf_pkg;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Entries carry the address at its widest legal size; the top keeps ADDR_W low bits.
    localparam int SB_ADDR_MAX = 32;

    typedef struct packed {
        logic [5:0]             opcode;
        logic [SB_ADDR_MAX-1:0] addr;
        logic [1:0]             byte_off;
        logic [31:0]            wd;
        logic [31:0]            pc;
    } sb_entry_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/store_buf_match.sv
// Load-address compare against all pending entries; reports the youngest hit.
module store_buf_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][5:0]        opcode,
    input  logic [PW-1:0]                tail,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         match,
    output logic [PW-1:0]                idx,
    output logic [5:0]                   opc
);

    logic [DEPTH-1:0] hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit[i] = valid[i] && (addr[i] == ld_addr);
    end

    // Walk from oldest slot (tail-DEPTH) to youngest (tail-1); the last hit seen wins.
    always_comb begin
        logic [PW-1:0] pos;
        pos = '0;
        idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            pos = tail - PW'(k);
            if (hit[pos]) idx = pos;
        end
        match = |hit;
        opc   = opcode[idx];
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of the data memory write port, with load hazard check.
// Optional store-to-load forwarding of sw data is enabled by defining STORE_BUF_FWD_EN.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [5:0]               st_opcode,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [1:0]               st_byte,
    input  logic [31:0]              st_wd,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_stall,
    output logic                     ld_fwd_valid,
    output logic [31:0]              ld_fwd_data,
    input  logic                     mem_port_busy,
    output logic                     dm_we,
    output logic [5:0]               dm_opcode,
    output logic [ADDR_W-1:0]        dm_addr,
    output logic [1:0]               dm_byte,
    output logic [31:0]              dm_wd,
    output logic [31:0]              dm_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW:0]           count;

    logic                          enq;
    logic [DEPTH-1:0]              vmask;
    logic [DEPTH-1:0][PW-1:0]      rel;
    logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr;
    logic [DEPTH-1:0][5:0]         ent_op;
    logic                          match;
    logic [PW-1:0]                 y_idx;
    logic [5:0]                    y_opc;
    sb_entry_t                     hd;

    assign st_ready  = count < (PW+1)'(DEPTH);
    assign enq       = st_valid && st_ready && is_store(st_opcode);
    // Reset cycle never writes, even though the head is still nominally valid.
    assign dm_we     = (count != '0) && !mem_port_busy && !reset;
    assign occupancy = count;

    assign hd        = mem[head];
    assign dm_opcode = hd.opcode;
    assign dm_addr   = hd.addr[ADDR_W-1:0];
    assign dm_byte   = hd.byte_off;
    assign dm_wd     = hd.wd;
    assign dm_pc     = hd.pc;

    // Slot i is live when its distance from head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign rel[i]      = PW'(i) - head;
        assign vmask[i]    = {1'b0, rel[i]} < count;
        assign ent_addr[i] = mem[i].addr[ADDR_W-1:0];
        assign ent_op[i]   = mem[i].opcode;
    end

    store_buf_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .valid   (vmask),
        .addr    (ent_addr),
        .opcode  (ent_op),
        .tail    (tail),
        .ld_addr (ld_addr),
        .match   (match),
        .idx     (y_idx),
        .opc     (y_opc)
    );

`ifdef STORE_BUF_FWD_EN
    logic fwd_hit;
    logic unused_bits;

    // Only a full-word store can satisfy a load; partial stores must drain first.
    assign fwd_hit      = ld_valid && match && (y_opc == OP_SW);
    assign ld_fwd_valid = fwd_hit;
    assign ld_fwd_data  = fwd_hit ? mem[y_idx].wd : 32'd0;
    assign ld_stall     = ld_valid && match && (y_opc != OP_SW);
    assign unused_bits  = ^hd.addr;
`else
    logic unused_bits;

    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'd0;
    assign ld_stall     = ld_valid && match;
    assign unused_bits  = ^{hd.addr, y_idx, y_opc};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            mem   <= '0;
        end else begin
            if (enq) begin
                mem[tail] <= '{opcode:   st_opcode,
                               addr:     SB_ADDR_MAX'(st_addr),
                               byte_off: st_byte,
                               wd:       st_wd,
                               pc:       st_pc};
                tail <= tail + 1'b1;
            end
            if (dm_we) head <= head + 1'b1;
            count <= count + (PW+1)'(enq) - (PW+1)'(dm_we);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes queued at issue, checked by a monitor.
module tb_store_buffer;
    import store_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [5:0]    st_opcode;
    logic [AW-1:0] st_addr;
    logic [1:0]    st_byte;
    logic [31:0]   st_wd;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;
    logic          mem_port_busy;
    logic          dm_we;
    logic [5:0]    dm_opcode;
    logic [AW-1:0] dm_addr;
    logic [1:0]    dm_byte;
    logic [31:0]   dm_wd;
    logic [31:0]   dm_pc;
    logic [$clog2(DEPTH):0] occupancy;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_opcode     (st_opcode),
        .st_addr       (st_addr),
        .st_byte       (st_byte),
        .st_wd         (st_wd),
        .st_pc         (st_pc),
        .st_ready      (st_ready),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_stall      (ld_stall),
        .ld_fwd_valid  (ld_fwd_valid),
        .ld_fwd_data   (ld_fwd_data),
        .mem_port_busy (mem_port_busy),
        .dm_we         (dm_we),
        .dm_opcode     (dm_opcode),
        .dm_addr       (dm_addr),
        .dm_byte       (dm_byte),
        .dm_wd         (dm_wd),
        .dm_pc         (dm_pc),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    op;
        logic [AW-1:0] addr;
        logic [1:0]    b;
        logic [31:0]   wd;
        logic [31:0]   pc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [5:0] op, input logic [AW-1:0] a, input logic [1:0] b,
                       input logic [31:0] wd, input logic [31:0] pc, input bit acc);
        st_valid  = 1'b1;
        st_opcode = op;
        st_addr   = a;
        st_byte   = b;
        st_wd     = wd;
        st_pc     = pc;
        if (acc) expq.push_back('{op, a, b, wd, pc});
    endtask

    // Every write the memory port sees must be the oldest outstanding expected store.
    always @(negedge clk) begin
        if (dm_we) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h, expected no write", dm_addr);
            end else begin
                mon_e = expq.pop_front();
                chk("wr_addr",   32'(dm_addr),   32'(mon_e.addr));
                chk("wr_data",   dm_wd,          mon_e.wd);
                chk("wr_opcode", 32'(dm_opcode), 32'(mon_e.op));
                chk("wr_byte",   32'(dm_byte),   32'(mon_e.b));
                chk("wr_pc",     dm_pc,          mon_e.pc);
            end
        end
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_opcode = '0; st_addr = '0; st_byte = '0;
        st_wd = '0; st_pc = '0; ld_valid = 1'b0; ld_addr = '0; mem_port_busy = 1'b0;

        // Reset state, with a load probing address 0 against cleared entries
        repeat (2) tick();
        ld_valid = 1'b1;
        #2;
        chk("rst_occupancy", 32'(occupancy),    32'd0);
        chk("rst_st_ready",  32'(st_ready),     32'd1);
        chk("rst_dm_we",     32'(dm_we),        32'd0);
        chk("rst_ld_stall",  32'(ld_stall),     32'd0);
        chk("rst_fwd_valid", 32'(ld_fwd_valid), 32'd0);
        chk("rst_dm_addr",   32'(dm_addr),      32'd0);
        chk("rst_dm_wd",     dm_wd,             32'd0);
        ld_valid = 1'b0;
        reset    = 1'b0;
        tick();

        // Single sw: written the cycle after enqueue
        put(OP_SW, 12'h010, 2'd0, 32'hDEADBEEF, 32'h0000_0400, 1'b1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("t1_dm_we",  32'(dm_we),     32'd1);
        chk("t1_dm_addr", 32'(dm_addr),  32'h010);
        chk("t1_dm_wd",  dm_wd,          32'hDEADBEEF);
        chk("t1_occ",    32'(occupancy), 32'd1);
        tick();
        #1;
        chk("t1_occ_after", 32'(occupancy), 32'd0);
        chk("t1_we_after",  32'(dm_we),     32'd0);

        // Fill while busy; fifth store refused; drain in order
        mem_port_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(OP_SW, AW'(i + 1), 2'd0, 32'h100 + 32'(i), 32'h500 + 32'(4 * i), i < 4);
            #1;
            chk("t2_st_ready", 32'(st_ready), 32'(i < 4));
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("t2_occ_full", 32'(occupancy), 32'd4);
        chk("t2_we_busy",  32'(dm_we),     32'd0);
        mem_port_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("t2_occ_drain", 32'(occupancy), 32'(3 - k));
        end

        // sb held in buffer: load hazard on exact word address only
        tick();
        mem_port_busy = 1'b1;
        put(OP_SB, 12'h020, 2'd2, 32'h0000_00AB, 32'h0000_0600, 1'b1);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 12'h020;
        #1;
        chk("t3_stall_hit", 32'(ld_stall), 32'd1);
        ld_addr = 12'h021;
        #1;
        chk("t3_stall_miss", 32'(ld_stall), 32'd0);
        ld_addr = 12'h020;
        #1;
        chk("t3_stall_hold", 32'(ld_stall), 32'd1);
        mem_port_busy = 1'b0;
        tick();
        #1;
        chk("t3_stall_drained", 32'(ld_stall),  32'd0);
        chk("t3_occ_drained",   32'(occupancy), 32'd0);
        ld_valid = 1'b0;

        // Two sw to same word; load sees the younger one (or stalls without forwarding)
        mem_port_busy = 1'b1;
        put(OP_SW, 12'h030, 2'd0, 32'h1111_1111, 32'h0000_0700, 1'b1);
        tick();
        put(OP_SW, 12'h030, 2'd0, 32'h2222_2222, 32'h0000_0704, 1'b1);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 12'h030;
        #1;
        chk("t4_occ", 32'(occupancy), 32'd2);
`ifdef STORE_BUF_FWD_EN
        chk("t4_fwd_valid", 32'(ld_fwd_valid), 32'd1);
        chk("t4_fwd_data",  ld_fwd_data,       32'h2222_2222);
        chk("t4_stall",     32'(ld_stall),     32'd0);
`else
        chk("t4_fwd_valid", 32'(ld_fwd_valid), 32'd0);
        chk("t4_fwd_data",  ld_fwd_data,       32'd0);
        chk("t4_stall",     32'(ld_stall),     32'd1);
`endif
        ld_valid      = 1'b0;
        mem_port_busy = 1'b0;
        tick();
        tick();
        #1;
        chk("t4_occ_drained", 32'(occupancy), 32'd0);

        // Full then steady enqueue+drain at occupancy 3; pointers wrap repeatedly
        mem_port_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put((i % 2 == 0) ? OP_SH : OP_SW, AW'(12'h040 + i), 2'(i),
                32'h0A0 + 32'(i), 32'h800 + 32'(4 * i), 1'b1);
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("t5_occ_full",   32'(occupancy), 32'd4);
        chk("t5_ready_full", 32'(st_ready),  32'd0);
        mem_port_busy = 1'b0;
        put(OP_SW, 12'h050, 2'd0, 32'h0BAD_0BAD, 32'h900, 1'b0);
        tick();
        #1;
        chk("t5_occ_3", 32'(occupancy), 32'd3);
        for (int j = 0; j < 5; j++) begin
            put((j % 2 == 0) ? OP_SW : OP_SB, AW'(12'h060 + j), 2'(j),
                32'hC0 + 32'(j), 32'hA00 + 32'(4 * j), 1'b1);
            #1;
            chk("t5_ready", 32'(st_ready), 32'd1);
            chk("t5_we",    32'(dm_we),    32'd1);
            tick();
            #1;
            chk("t5_occ_steady", 32'(occupancy), 32'd3);
        end
        st_valid = 1'b0;
        repeat (3) tick();
        #1;
        chk("t5_occ_drained", 32'(occupancy), 32'd0);

        // Reset with pending entries discards them and blocks the write
        mem_port_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(OP_SW, AW'(12'h070 + i), 2'd0, 32'hE0 + 32'(i), 32'hB00, 1'b0);
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("t6_occ_pending", 32'(occupancy), 32'd3);
        reset         = 1'b1;
        mem_port_busy = 1'b0;
        #1;
        chk("t6_we_in_reset", 32'(dm_we), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_occ_after", 32'(occupancy), 32'd0);
        chk("t6_we_after",  32'(dm_we),     32'd0);
        chk("t6_ready",     32'(st_ready),  32'd1);

        // lw on the store port is dropped
        put(6'b100011, 12'h080, 2'd0, 32'h1234_5678, 32'hC00, 1'b0);
        tick();
        st_valid = 1'b0;
        #1;
        chk("t7_lw_occ", 32'(occupancy), 32'd0);
        chk("t7_lw_we",  32'(dm_we),     32'd0);

        repeat (3) tick();
        chk("sb_empty", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
